// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: owns pcF, drives the imem request/ack handshake and defers
// redirects until the delay-slot fetch completes. Define PC_ALIGN_CHECK_EN to add pc_adelF.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        branchD,
  input  logic        equalD,
  input  logic        jumpD,
  input  logic        jrD,
  input  logic [31:0] pc_plus4D,
  input  logic [31:0] imm_extD,
  input  logic [25:0] instr_indexD,
  input  logic [31:0] rs_valueD,
  input  logic        exc_redirect,
  input  logic [31:0] exc_pc,
  input  logic        inst_ack,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  output logic [31:0] pcF,
  output logic [31:0] pc_plus4F,
`ifdef PC_ALIGN_CHECK_EN
  output logic        pc_adelF,
`endif
  output logic        inst_validF
);

  typedef enum logic [1:0] {S_REQ, S_HELD, S_DROP} state_t;

  state_t      state, state_d;
  logic [31:0] pc_d;
  logic        pend_valid, pend_valid_d;
  logic [31:0] pend_pc, pend_pc_d;
  logic [31:0] exc_slot, exc_slot_d;

  logic        redirect_now, take_redirect;
  logic        fetch_fault, fetch_done, advance;
  logic [31:0] branch_target, jump_target, redirect_target, seq_pc;

  assign pc_plus4F     = pcF + 32'd4;
  assign branch_target = pc_plus4D + {imm_extD[29:0], 2'b00};
  assign jump_target   = {pc_plus4D[31:28], instr_indexD, 2'b00};
  assign redirect_now  = !stallD && (jumpD || jrD || (branchD && equalD));
  // A redirect seen while one is already pending sits in a delay slot and is dropped.
  assign take_redirect = redirect_now && !pend_valid;

  assign redirect_target = jrD   ? rs_valueD :
                           jumpD ? jump_target : branch_target;

  assign seq_pc = exc_redirect  ? exc_pc :
                  take_redirect ? redirect_target :
                  pend_valid    ? pend_pc : pc_plus4F;

`ifdef PC_ALIGN_CHECK_EN
  // A misaligned PC never reaches memory; the fetch retires internally with an error flag.
  assign fetch_fault = (state == S_REQ) && (pcF[1:0] != 2'b00);
  assign inst_addr   = pcF;
  assign pc_adelF    = !rst && fetch_fault;
`else
  assign fetch_fault = 1'b0;
  assign inst_addr   = {pcF[31:2], 2'b00};
`endif

  assign fetch_done  = (state == S_REQ) && (inst_ack || fetch_fault);
  assign inst_req    = !rst && (state != S_HELD) && !fetch_fault;
  assign inst_validF = !rst && fetch_done && !exc_redirect;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state;
    pc_d         = pcF;
    pend_valid_d = pend_valid;
    pend_pc_d    = pend_pc;
    exc_slot_d   = exc_slot;
    advance      = 1'b0;

    case (state)
      S_REQ: begin
        if (exc_redirect && !fetch_done) begin
          exc_slot_d = exc_pc;
          state_d    = S_DROP;
        end else if (fetch_done) begin
          if (stallF && !exc_redirect) state_d = S_HELD;
          else                         advance = 1'b1;
        end
      end
      S_HELD: begin
        if (!stallF || exc_redirect) begin
          advance = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        // The handshake cannot be withdrawn; the returning data is thrown away.
        if (exc_redirect) exc_slot_d = exc_pc;
        if (inst_ack) begin
          pc_d    = exc_redirect ? exc_pc : exc_slot;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (advance) begin
      pc_d         = seq_pc;
      pend_valid_d = 1'b0;
    end else if (take_redirect) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = redirect_target;
    end

    if (exc_redirect || (state == S_DROP && inst_ack)) pend_valid_d = 1'b0;
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pcF        <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      exc_slot   <= '0;
    end else begin
      state      <= state_d;
      pcF        <= pc_d;
      pend_valid <= pend_valid_d;
      pend_pc    <= pend_pc_d;
      exc_slot   <= exc_slot_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed scenarios then randomized traffic against
// a behavioural fetch model. Honours PC_ALIGN_CHECK_EN when the design is built with it.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, stallD, branchD, equalD, jumpD, jrD;
  logic [31:0] pc_plus4D, imm_extD, rs_valueD, exc_pc;
  logic [25:0] instr_indexD;
  logic        exc_redirect, inst_ack;
  logic        inst_req, inst_validF, pc_adelF;
  logic [31:0] inst_addr, pcF, pc_plus4F;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
    .branchD(branchD), .equalD(equalD), .jumpD(jumpD), .jrD(jrD),
    .pc_plus4D(pc_plus4D), .imm_extD(imm_extD), .instr_indexD(instr_indexD),
    .rs_valueD(rs_valueD), .exc_redirect(exc_redirect), .exc_pc(exc_pc),
    .inst_ack(inst_ack), .inst_req(inst_req), .inst_addr(inst_addr),
    .pcF(pcF), .pc_plus4F(pc_plus4F),
`ifdef PC_ALIGN_CHECK_EN
    .pc_adelF(pc_adelF),
`endif
    .inst_validF(inst_validF)
  );

`ifndef PC_ALIGN_CHECK_EN
  assign pc_adelF = 1'b0;
`endif

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic        adel;
  } cyc_t;

  cyc_t        cyc_q[$];
  logic [31:0] fetch_q[$];
  int          tests = 0;
  int          failed = 0;

  // Reference model: where fetch is, whether it waits on a stall or discards a dead fetch.
  logic [31:0] m_pc, m_exc;
  bit          m_hold, m_drop;
  logic [31:0] m_pend[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc   = RESET_PC;
    m_exc  = 32'h0;
    m_hold = 1'b0;
    m_drop = 1'b0;
    m_pend.delete();
  endfunction

  task automatic clear_inputs();
    stallF = 0; stallD = 0; branchD = 0; equalD = 0; jumpD = 0; jrD = 0;
    pc_plus4D = 0; imm_extD = 0; instr_indexD = 0; rs_valueD = 0;
    exc_redirect = 0; exc_pc = 0; inst_ack = 0;
  endtask

  // Called just after an edge with this cycle's inputs applied: predicts, then clocks.
  task automatic step();
    cyc_t        e;
    logic [31:0] tgt;
    bit          fault, done, redirect, moves;

    fault  = ALIGN_CHK && !m_hold && !m_drop && (m_pc % 4 != 0);
    done   = !m_hold && !m_drop && (inst_ack || fault);
    e.req  = m_drop || (!m_hold && !fault);
    e.addr = ALIGN_CHK ? m_pc : (m_pc >> 2) << 2;
    e.pc   = m_pc;
    e.adel = fault;
    cyc_q.push_back(e);
    if (done && !exc_redirect) fetch_q.push_back(m_pc);

    if (jrD)        tgt = rs_valueD;
    else if (jumpD) tgt = (pc_plus4D & 32'hF000_0000) + {6'd0, instr_indexD} * 32'd4;
    else            tgt = pc_plus4D + imm_extD * 32'd4;
    redirect = !stallD && (jumpD || jrD || (branchD && equalD)) && m_pend.size() == 0;

    if (exc_redirect) begin
      if (m_drop) begin
        if (inst_ack) begin m_pc = exc_pc; m_drop = 0; end
        else m_exc = exc_pc;
      end else if (m_hold || done) begin
        m_pc = exc_pc; m_hold = 0;
      end else begin
        m_exc = exc_pc; m_drop = 1;
      end
      m_pend.delete();
    end else if (m_drop) begin
      if (inst_ack) begin m_pc = m_exc; m_drop = 0; m_pend.delete(); end
      else if (redirect) m_pend.push_back(tgt);
    end else begin
      moves = m_hold ? !stallF : (done && !stallF);
      if (moves) begin
        m_pc   = redirect ? tgt : (m_pend.size() > 0 ? m_pend[0] : m_pc + 32'd4);
        m_hold = 0;
        m_pend.delete();
      end else begin
        if (done) m_hold = 1;
        if (redirect) m_pend.push_back(tgt);
      end
    end

    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the presented outputs once per cycle, and each valid fetch in order.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        cyc_t e;
        e = cyc_q.pop_front();
        check("inst_req", {31'd0, inst_req}, {31'd0, e.req});
        check("inst_addr", inst_addr, e.addr);
        check("pcF", pcF, e.pc);
        check("pc_plus4F", pc_plus4F, e.pc + 32'd4);
`ifdef PC_ALIGN_CHECK_EN
        check("pc_adelF", {31'd0, pc_adelF}, {31'd0, e.adel});
`endif
      end
      if (inst_validF) begin
        if (fetch_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL inst_validF: got 1 with no fetch due, required 0");
        end else begin
          check("valid fetch pc", pcF, fetch_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] r;
    int          sel;

    clear_inputs();
    rst = 1'b1;
    inst_ack = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset pcF", pcF, RESET_PC);
    check("reset pc_plus4F", pc_plus4F, RESET_PC + 32'd4);
    check("reset inst_req", {31'd0, inst_req}, 32'd0);
    check("reset inst_validF", {31'd0, inst_validF}, 32'd0);
    check("reset pc_adelF", {31'd0, pc_adelF}, 32'd0);
    rst = 1'b0;
    #1;
    check("first inst_req", {31'd0, inst_req}, 32'd1);
    step(); check("seq pc 1", pcF, 32'hBFC0_0004);
    step(); check("seq pc 2", pcF, 32'hBFC0_0008);

    // Taken branch whose delay-slot fetch is acked three cycles late.
    clear_inputs(); inst_ack = 1; jrD = 1; rs_valueD = 32'h100; step();
    clear_inputs(); inst_ack = 1; step();
    check("delay slot pc", pcF, 32'h104);
    clear_inputs(); branchD = 1; equalD = 1; pc_plus4D = 32'h104; imm_extD = 32'h10; step();
    check("branch wait 1", pcF, 32'h104);
    clear_inputs(); step(); step();
    check("branch wait 3", pcF, 32'h104);
    clear_inputs(); inst_ack = 1; step();
    check("branch target", pcF, 32'h144);
    step();
    check("pending cleared", pcF, 32'h148);

    // jr whose delay-slot ack lands under stallF.
    clear_inputs(); inst_ack = 1; stallF = 1; jrD = 1; rs_valueD = 32'h8000_0200; step();
    check("held pcF", pcF, 32'h148);
    check("held inst_req", {31'd0, inst_req}, 32'd0);
    clear_inputs(); stallF = 1; step();
    check("still held pcF", pcF, 32'h148);
    clear_inputs(); step();
    check("jr target", pcF, 32'h8000_0200);
    check("req after held", {31'd0, inst_req}, 32'd1);

    // Exception while the request is outstanding.
    clear_inputs(); exc_redirect = 1; exc_pc = 32'hBFC0_0380; step();
    check("drop pcF", pcF, 32'h8000_0200);
    check("drop inst_addr", inst_addr, 32'h8000_0200);
    check("drop inst_req", {31'd0, inst_req}, 32'd1);
    clear_inputs(); inst_ack = 1; step();
    check("exc target addr", inst_addr, 32'hBFC0_0380);

    // Wrap past the top of the address space, then a j.
    clear_inputs(); inst_ack = 1; jrD = 1; rs_valueD = 32'hFFFF_FFFC; step();
    check("top pc", pcF, 32'hFFFF_FFFC);
    clear_inputs(); inst_ack = 1; step();
    check("wrap pc", pcF, 32'h0);
    clear_inputs(); inst_ack = 1; jumpD = 1; pc_plus4D = 32'h4000_0008; instr_indexD = 26'h10; step();
    check("jump target", pcF, 32'h4000_0040);

    // jr to a misaligned address.
    clear_inputs(); inst_ack = 1; jrD = 1; rs_valueD = 32'h1002; step();
    check("misaligned pc", pcF, 32'h1002);
`ifdef PC_ALIGN_CHECK_EN
    check("adel inst_req", {31'd0, inst_req}, 32'd0);
    check("adel flag", {31'd0, pc_adelF}, 32'd1);
    clear_inputs(); step();
`else
    check("aligned inst_addr", inst_addr, 32'h1000);
    clear_inputs(); inst_ack = 1; step();
`endif
    check("after misaligned", pcF, 32'h1006);

    // Randomized traffic with a reset dropped in midway.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("async reset pcF", pcF, RESET_PC);
        check("async reset inst_req", {31'd0, inst_req}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      sel          = $urandom_range(0, 99);
      inst_ack     = ($urandom_range(0, 99) < 60);
      stallF       = ($urandom_range(0, 99) < 20);
      stallD       = ($urandom_range(0, 99) < 20);
      branchD      = (sel < 15);
      jumpD        = (sel >= 15 && sel < 20);
      jrD          = (sel >= 20 && sel < 25);
      equalD       = ($urandom_range(0, 1) == 1);
      pc_plus4D    = $urandom;
      r            = $urandom;
      imm_extD     = {{16{r[15]}}, r[15:0]};
      instr_indexD = r[31:6];
      r            = $urandom;
      rs_valueD    = ($urandom_range(0, 7) == 0) ? r : {r[31:2], 2'b00};
      exc_redirect = ($urandom_range(0, 99) < 5);
      exc_pc       = $urandom & 32'hFFFF_FFFC;
      step();
    end

    check("fetch queue drained", fetch_q.size(), 32'd0);
    check("cycle queue drained", cyc_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
